// File: rtl/step_phase_tracker.sv
// Passive monitor of the 4-bit coil-pattern bus: tracks half-step position, angle and revolutions.
// Optional soft-limit flag is built only when STEP_LIMIT_EN is defined.
module step_phase_tracker #(
  parameter int POS_W      = 16,
  parameter int REV_HSTEPS = 400,
  parameter int REV_W      = 8,
  parameter int POS_LIMIT  = 4000
) (
  input  logic                    clk,
  input  logic                    resetb,
  input  logic [3:0]              pulses_in,
  input  logic                    zero_pos,
  input  logic                    clear_err,
  output logic signed [POS_W-1:0] position,
  output logic [8:0]              angle,
  output logic signed [REV_W-1:0] rev_count,
  output logic                    step_valid,
  output logic                    step_dir,
  output logic                    half_mode,
  output logic                    illegal_err,
  output logic                    limit_hit
);

  typedef enum logic {IDLE, TRACK} state_t;

  state_t     state;
  logic [3:0] pattern_q;
  logic [2:0] ref_idx;

  logic       pat_valid;
  logic       pat_off;
  logic [2:0] pat_idx;

  always_comb begin
    pat_valid = 1'b1;
    pat_off   = 1'b0;
    pat_idx   = 3'd0;
    case (pattern_q)
      4'b1000: pat_idx = 3'd0;
      4'b1100: pat_idx = 3'd1;
      4'b0100: pat_idx = 3'd2;
      4'b0110: pat_idx = 3'd3;
      4'b0010: pat_idx = 3'd4;
      4'b0011: pat_idx = 3'd5;
      4'b0001: pat_idx = 3'd6;
      4'b1001: pat_idx = 3'd7;
      4'b0000: begin
        pat_valid = 1'b0;
        pat_off   = 1'b1;
      end
      default: pat_valid = 1'b0;
    endcase
  end

  // 3-bit subtraction gives the phase distance modulo 8 for free
  logic [2:0] delta;
  assign delta = pat_idx - ref_idx;

  logic move_en;
  logic move_up;
  logic move_half;
  logic illegal_evt;

  always_comb begin
    move_en   = 1'b0;
    move_up   = 1'b0;
    move_half = 1'b0;
    if (state == TRACK && pat_valid) begin
      case (delta)
        3'd1: begin move_en = 1'b1; move_up = 1'b1; move_half = 1'b1; end
        3'd7: begin move_en = 1'b1; move_half = 1'b1; end
        3'd2: begin move_en = 1'b1; move_up = 1'b1; end
        3'd6: move_en = 1'b1;
        default: ;
      endcase
    end
  end

  assign illegal_evt = (state == TRACK) &&
                       ((pat_valid && (delta inside {3'd3, 3'd4, 3'd5})) ||
                        (!pat_valid && !pat_off));

  int                    step_amt;
  int                    angle_sum;
  logic [8:0]            angle_next;
  logic signed [REV_W-1:0] rev_next;
  logic signed [POS_W-1:0] pos_next;

  always_comb begin
    step_amt   = move_half ? 1 : 2;
    step_amt   = move_up ? step_amt : -step_amt;
    angle_sum  = int'(angle) + step_amt;
    angle_next = 9'(angle_sum);
    rev_next   = rev_count;
    if (angle_sum >= REV_HSTEPS) begin
      angle_next = 9'(angle_sum - REV_HSTEPS);
      rev_next   = rev_count + REV_W'(1);
    end else if (angle_sum < 0) begin
      angle_next = 9'(angle_sum + REV_HSTEPS);
      rev_next   = rev_count - REV_W'(1);
    end
    pos_next = position + POS_W'(step_amt);
  end

  // zero_pos and error-set are placed last so they win over the move and the clear
  always_ff @(posedge clk) begin
    if (resetb) begin
      state       <= IDLE;
      ref_idx     <= 3'd0;
      pattern_q   <= 4'b0000;
      position    <= '0;
      angle       <= '0;
      rev_count   <= '0;
      step_valid  <= 1'b0;
      step_dir    <= 1'b0;
      half_mode   <= 1'b0;
      illegal_err <= 1'b0;
    end else begin
      pattern_q  <= pulses_in;
      step_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pat_valid) begin
            ref_idx <= pat_idx;
            state   <= TRACK;
          end
        end
        TRACK: begin
          if (pat_valid) ref_idx <= pat_idx;
          else           state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (move_en) begin
        position   <= pos_next;
        angle      <= angle_next;
        rev_count  <= rev_next;
        step_valid <= 1'b1;
        step_dir   <= move_up;
        half_mode  <= move_half;
      end
      if (zero_pos) begin
        position  <= '0;
        angle     <= '0;
        rev_count <= '0;
      end
      if (clear_err)   illegal_err <= 1'b0;
      if (illegal_evt) illegal_err <= 1'b1;
    end
  end

`ifdef STEP_LIMIT_EN
  assign limit_hit = (int'(position) >= POS_LIMIT) || (int'(position) <= -POS_LIMIT);
`else
  assign limit_hit = 1'b0;
`endif

endmodule
